ram_arbiter: RTL and testbench

Sequencer that shares the single-port 512x32 system RAM between the instruction-fetch requester and the load/store data requester. It drives the RAM's `read`, `write`, `address` and `ram_data_in` pins, and compensates for the RAM's one-cycle registered-address read latency. It returns read data to the winning requester through a fixed-latency response handshake. Data accesses have priority, and a starvation limiter guarantees fetch progress.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch
// requester (F, read-only) and a load/store data requester (D).
//
// Ports:
//   clock, clear_n                 clock and synchronous active-low reset
//   f_req/f_addr                   fetch request, held until f_ack
//   f_ack/f_rvalid/f_rdata         fetch issue pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata      data request (store when d_we=1)
//   d_ack/d_rvalid/d_rdata         data issue pulse, load response, data
//   ram_read/ram_write             RAM strobes
//   ram_address/ram_data_in        RAM address and write data
//   ram_data_out                   RAM read data, one cycle after address
//   busy                           high whenever the sequencer is not idle
//
// state   | meaning
// IDLE    | sample requests, arbitrate, latch winner
// ACCESS  | drive RAM strobe and owner's ack
// CAPTURE | RAM read data valid, latch into owner's rdata register
// RESP    | pulse owner's rvalid
module ram_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic                owner_d_q, owner_d_d;   // 1 = data requester owns the access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          starve_q, starve_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                f_win;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_win     = 1'b0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    f_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // Fetch wins when alone, or when data has won LIMIT times in a row.
          f_win     = f_req && (!d_req || starve_q == LIMIT);
          owner_d_d = !f_win;
          addr_d    = f_win ? f_addr : d_addr;
          we_d      = !f_win && d_we;
          if (!f_win) wdata_d = d_wdata;
          if (f_win || !f_req)
            starve_d = '0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_write = we_q;
        ram_read  = !we_q;
        f_ack     = !owner_d_q;
        d_ack     = owner_d_q;
        state_d   = we_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (owner_d_q) d_rdata_d = ram_data_out;
        else           f_rdata_d = ram_data_out;
        state_d = RESP;
      end
      RESP: begin
        f_rvalid = !owner_d_q;
        d_rvalid = owner_d_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and write data come straight from the latch registers; they are
  // only meaningful while a strobe is high but stay stable through CAPTURE.
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign f_rdata     = f_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          clear_n;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_ack, f_rvalid, d_ack, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          ram_read, ram_write, busy;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  int n_total = 0;
  int n_bad = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .clear_n(clear_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h05) return 32'h0900_0095;
    if (i == 'h95) return 32'h5A5A_0095;
    return (32'(i) * 32'h0001_0003) ^ 32'hA500_0000;
  endfunction

  // Behavioural RAM: write at the edge, registered read data.
  logic [DW-1:0] mem [512];
  logic [DW-1:0] shadow [512];
  initial begin
    ram_data_out <= '0;
    for (int i = 0; i < 512; i++) begin
      mem[i]    <= init_word(i);
      shadow[i]  = init_word(i);
    end
  end
  always @(posedge clock) begin
    if (ram_write) mem[ram_address] <= ram_data_in;
    if (ram_read)  ram_data_out <= mem[ram_address];
  end

  // Transaction-level reference: serialized accesses, data priority, and a
  // count of consecutive data wins while fetch waits.
  int            cyc = 0;
  int            streak = 0;
  bit            pend = 0;
  bit            pend_d;
  int            pend_cyc;
  logic [DW-1:0] pend_data;

  always @(negedge clock) begin
    logic          exp_d, is_st;
    logic [AW-1:0] exp_addr;
    cyc++;
    if (!clear_n) begin
      check_val("rst_ctrl", {busy, f_ack, d_ack, f_rvalid, d_rvalid, ram_read, ram_write}, 0);
      check_val("rst_data", {f_rdata, d_rdata, ram_address, ram_data_in}, 0);
      pend   = 0;
      streak = 0;
    end else begin
      check_val("strobe_excl", ram_read & ram_write, 0);
      check_val("ack_excl", f_ack & d_ack, 0);
      check_val("rv_excl", f_rvalid & d_rvalid, 0);
      if (f_ack || d_ack) begin
        exp_d = d_req && !(f_req && streak == LIMIT);
        check_val("grant_req", d_ack ? d_req : f_req, 1);
        check_val("grant_who", d_ack, exp_d);
        if (d_ack) streak = f_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        else       streak = 0;
        exp_addr = d_ack ? d_addr : f_addr;
        is_st    = d_ack && d_we;
        check_val("acc_addr", ram_address, exp_addr);
        check_val("acc_strobe", {ram_write, ram_read}, is_st ? 2'b10 : 2'b01);
        check_val("busy_acc", busy, 1);
        if (is_st) begin
          check_val("st_data", ram_data_in, d_wdata);
          shadow[d_addr] = d_wdata;
        end else begin
          pend      = 1;
          pend_d    = d_ack;
          pend_cyc  = cyc + 2;
          pend_data = shadow[exp_addr];
        end
      end
      if (f_rvalid || d_rvalid) begin
        check_val("rv_timing", pend && cyc == pend_cyc, 1);
        check_val("rv_owner", d_rvalid, pend_d);
        check_val("rv_data", d_rvalid ? d_rdata : f_rdata, pend_data);
        pend = 0;
      end else if (pend && cyc >= pend_cyc) begin
        check_val("rv_missing", 0, 1);
        pend = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  // Waits for the chosen ack, returns the number of negedges waited; leaves
  // time just after the negedge of the ack cycle.
  task automatic wait_ack(input bit want_d, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(want_d ? d_ack : f_ack) && n < 50);
    if (!(want_d ? d_ack : f_ack)) check_val("ack_timeout", 0, 1);
    #1;
  endtask

  initial begin
    int n;
    logic grants [$];
    logic exp_order [10];
    logic fa, da;

    clear_n = 0; f_req = 1; f_addr = 9'h05;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset held with a pending fetch; release grants fetch right away.
    idle(2);
    clear_n = 1;
    @(negedge clock);
    check_val("rel_f_ack", f_ack, 1);
    #1 f_req = 0;
    @(negedge clock);
    @(negedge clock);
    check_val("fetch_rvalid", f_rvalid, 1);
    check_val("fetch_rdata", f_rdata, 32'h0900_0095);
    check_val("fetch_d_quiet", {d_rvalid, d_rdata}, 0);
    idle(2);

    // Store, then load back.
    d_req = 1; d_we = 1; d_addr = 9'h87; d_wdata = 32'hDEAD_BEEF;
    wait_ack(1, n);
    check_val("st_write", {ram_write, ram_address}, {1'b1, 9'h87});
    d_req = 0;
    @(negedge clock);
    check_val("st_no_rv", {d_rvalid, busy}, 0);
    #1;
    d_req = 1; d_we = 0;
    wait_ack(1, n);
    d_req = 0;
    @(negedge clock);
    @(negedge clock);
    check_val("ld_rvalid", d_rvalid, 1);
    check_val("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    idle(2);

    // Simultaneous requests with no starvation history.
    f_req = 1; f_addr = 9'h10; d_req = 1; d_we = 0; d_addr = 9'h20;
    @(negedge clock);
    check_val("simul_d_first", {d_ack, f_ack}, 2'b10);
    #1 d_req = 0;
    wait_ack(0, n);
    check_val("simul_f_gap", n, 4);
    f_req = 0;
    idle(4);

    // Starvation: both held high continuously.
    clear_n = 0; idle(1); clear_n = 1;
    f_req = 1; f_addr = 9'h33; d_req = 1; d_we = 0; d_addr = 9'h01;
    for (int c = 0; c < 120 && grants.size() < 10; c++) begin
      @(negedge clock);
      da = d_ack; fa = f_ack;
      if (da) grants.push_back(1'b1);
      if (fa) grants.push_back(1'b0);
      #1;
      if (da) d_addr = 9'($urandom_range(0, 15));
    end
    f_req = 0; d_req = 0;
    for (int i = 0; i < 10; i++) exp_order[i] = (i != 4 && i != 9);
    check_val("starve_count", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check_val($sformatf("starve_order%0d", i), grants[i], exp_order[i]);
    idle(6);

    // Reset during CAPTURE of a fetch abandons it; reissue returns data.
    f_req = 1; f_addr = 9'h95;
    wait_ack(0, n);
    @(negedge clock);
    check_val("cap_busy", busy, 1);
    #1 clear_n = 0;
    @(negedge clock);
    check_val("rst_mid_quiet", {f_rvalid, busy}, 0);
    #1 clear_n = 1;
    wait_ack(0, n);
    f_req = 0;
    @(negedge clock);
    @(negedge clock);
    check_val("reissue_rvalid", f_rvalid, 1);
    check_val("reissue_rdata", f_rdata, 32'h5A5A_0095);
    idle(3);

    // Random traffic; the monitor checks every grant and response.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      fa = f_ack; da = d_ack;
      #1;
      if (fa) f_req = 0;
      if (da) d_req = 0;
      if (c < 2900) begin
        if (!f_req && $urandom_range(0, 2) == 0) begin
          f_req  = 1;
          f_addr = 9'($urandom_range(0, 15));
        end
        if (!d_req && $urandom_range(0, 1) == 0) begin
          d_req   = 1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = 9'($urandom_range(0, 15));
          d_wdata = $urandom;
        end
      end
    end
    check_val("drain_reqs", {f_req, d_req}, 0);
    idle(6);
    check_val("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
